mem_access_ctrl: RTL and testbench

- CPU-side initiator for the 32-bit byte-banked data memory. The memory takes a read address, a write address, Datain, Dataout and Wr, with a registered read; Dataout[7:0] is always the byte at the read address.
- Serves load/store requests from the pipeline: byte, half and word accesses, with sign or zero extension on loads.
- The memory has no byte enables, so sub-word stores are done as read-modify-write.
- Sits between the execute/memory stage and the data memory instance.

---
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the byte-banked data memory; sub-word stores are read-modify-write.
// Define MEM_ACCESS_BOUNDS_CHECK_EN to reject accesses that leave the low 64 KiB window.
module mem_access_ctrl #(
  parameter int MEM_RD_LATENCY = 1,
  parameter int ADDR_W         = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        acc_err;
  logic        word_store;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [2:0]  cnt_q;
  logic [31:0] merged;
  logic [63:0] load_ext;

  assign accept     = req_valid && (state == IDLE);
  assign word_store = req_we && req_size[1];
  assign rsp_err    = err_q;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  logic [1:0]  last_off;
  logic [16:0] end_addr;

  always_comb begin
    case (req_size)
      2'b00:   last_off = 2'd0;
      2'b01:   last_off = 2'd1;
      default: last_off = 2'd3;
    endcase
  end

  // Carry out of the low 16 bits means the access runs past 16'hFFFF.
  assign end_addr = {1'b0, req_addr[15:0]} + {15'd0, last_off};
  assign acc_err  = (|req_addr[ADDR_W-1:16]) || end_addr[16];
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    case (size_q)
      2'b00:   merged = {mem_rdata[31:8], wdata_q[7:0]};
      2'b01:   merged = {mem_rdata[31:16], wdata_q[15:0]};
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{56{~uns_q & mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   load_ext = {{48{~uns_q & mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_ext = {{32{~uns_q & mem_rdata[31]}}, mem_rdata};
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_err)         state_nxt = RESP;
          else if (word_store) state_nxt = WRITE;
          else                 state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) state_nxt = we_q ? WRITE : RESP;
      end
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      WRITE:   mem_wr    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= 32'd0;
      cnt_q     <= 3'd0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= 32'd0;
      rsp_rdata <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            size_q    <= req_size;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            err_q     <= acc_err;
            wdata_q   <= req_wdata;
            cnt_q     <= 3'(MEM_RD_LATENCY);
            mem_raddr <= req_addr;
            mem_waddr <= req_addr;
            // A word store needs no read, so its write data is final already.
            mem_wdata <= req_wdata;
            rsp_rdata <= 64'd0;
          end
        end
        RD_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else if (we_q) begin
            mem_wdata <= merged;
          end else begin
            rsp_rdata <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl against a byte-array reference model.
module tb_mem_access_ctrl;
  localparam int L = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] mem_raddr;
  logic [63:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  mem_access_ctrl #(.MEM_RD_LATENCY(L), .ADDR_W(64)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Bus-side memory: any byte address, L-cycle registered read, 4-byte write.
  logic [7:0]  mem_arr [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] rd_pipe [0:L-1];

  function automatic logic [31:0] rd_word(input logic [15:0] a);
    return {mem_arr[a + 16'd3], mem_arr[a + 16'd2], mem_arr[a + 16'd1], mem_arr[a]};
  endfunction

  always @(posedge Clk) begin
    rd_pipe[0] <= rd_word(mem_raddr[15:0]);
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wr)
      for (int i = 0; i < 4; i++) mem_arr[mem_waddr[15:0] + 16'(i)] <= mem_wdata[8*i +: 8];
  end
  assign mem_rdata = rd_pipe[L-1];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wexp_t;

  exp_t  exp_q[$];
  wexp_t wr_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: response and write-strobe checking, decoupled from the driver.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got mem_wr=1 waddr=%h expected no write", mem_waddr);
        end else begin
          wexp_t w;
          w = wr_q.pop_front();
          chk("mem_waddr", mem_waddr, w.addr);
          chk("mem_wdata", 64'(mem_wdata), 64'(w.data));
        end
      end
    end
  end

  // Reference model: expected results from the byte-array view of memory.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [31:0] wd, input int acc);
    int          n;
    logic        err;
    exp_t        e;
    wexp_t       w;
    logic [63:0] v;
    logic [15:0] a;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = 1'b0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    err = (addr[63:16] != 48'd0) || (int'(addr[15:0]) + n - 1 > 65535);
`endif
    a       = addr[15:0];
    e.acc   = acc;
    e.err   = err;
    e.rdata = 64'd0;
    if (err) begin
      e.lat = 1;
    end else if (we) begin
      e.lat = (n == 4) ? 2 : L + 3;
      for (int i = 0; i < 4; i++)
        if (i < n) ref_mem[a + 16'(i)] = wd[8*i +: 8];
      w.addr = addr;
      w.data = {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
      wr_q.push_back(w);
    end else begin
      e.lat = L + 2;
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + 16'(i)];
      if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e.rdata = v;
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge; garbage is kept on req_* with valid high while busy.
  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = {32'd0, $urandom}; req_wdata = $urandom;
      @(negedge Clk);
      k++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [31:0] wd, input bit track);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    if (track) model(we, sz, uns, addr, wd, cyc + 1);
    @(negedge Clk);
    req_valid = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    logic [63:0] ra;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      mem_arr[i] = b;
      ref_mem[i] = b;
    end
    repeat (3) @(negedge Clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_mem_wr", 64'(mem_wr), 64'd0);
    chk("reset_mem_raddr", mem_raddr, 64'd0);
    chk("reset_mem_waddr", mem_waddr, 64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    do_req(1'b1, 2'b10, 1'b0, 64'h100, 32'hDEADBEEF, 1'b1);
    do_req(1'b1, 2'b00, 1'b0, 64'h100, 32'h00000055, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 64'h100, 32'h0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 64'h100, 32'h000000F0, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 64'h100, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 1'b1, 64'h100, 32'h0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 64'h203, 32'h11223344, 1'b1);
    do_req(1'b1, 2'b01, 1'b0, 64'h203, 32'h9999ABCD, 1'b1);
    do_req(1'b0, 2'b10, 1'b1, 64'h203, 32'h0, 1'b1);
    do_req(1'b0, 2'b01, 1'b1, 64'h203, 32'h0, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 64'h203, 32'h0, 1'b1);
    do_req(1'b1, 2'b11, 1'b0, 64'h208, 32'h8000_0001, 1'b1);
    do_req(1'b0, 2'b11, 1'b0, 64'h208, 32'h0, 1'b1);

    // Byte store aborted by reset while waiting on the read: nothing may reach memory.
    do_req(1'b1, 2'b00, 1'b0, 64'h300, 32'h000000A5, 1'b0);
    req_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_midop_mem_wr", 64'(mem_wr), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("after_reset_req_ready", 64'(req_ready), 64'd1);
    repeat (L + 4) @(negedge Clk);
    do_req(1'b0, 2'b10, 1'b1, 64'h300, 32'h0, 1'b1);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    do_req(1'b0, 2'b10, 1'b0, 64'hFFFE, 32'h0, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 64'h10000, 32'h12345678, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 64'hFFFF, 32'h0, 1'b1);
`endif

    for (int i = 0; i < 250; i++) begin
      ra = 64'($urandom_range(0, 511));
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
      if ($urandom_range(0, 7) == 0) ra = 64'hFFF8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ra = 64'h10000 + 64'($urandom_range(0, 3));
`endif
      do_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, 1'b1);
    end

    wait_ready();
    req_valid = 1'b0;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || wr_q.size() != 0); k++) @(negedge Clk);
    chk("pending_rsp", 64'(exp_q.size()), 64'd0);
    chk("pending_wr", 64'(wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
